seg7_display_arbiter: RTL and testbench



---
 rtl/seg7_pkg.sv | 34 +++
 rtl/rr_pick.sv | 32 +++
 rtl/seg7_display_arbiter.sv | 137 +++++++++++++
 tb/tb_seg7_display_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 7-segment display arbiter family.
// Holds the arbiter state encoding and the BCD sanitiser.
package seg7_pkg;

  localparam int DIGITS        = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int DWELL_DEFAULT = 50_000_000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [15:0] value;
    logic        err;
  } bcd_clean_t;

  // Any nibble above 9 is forced to 0 so the driver never decodes garbage.
  function automatic bcd_clean_t bcd_sanitise(input logic [15:0] raw);
    bcd_clean_t res;
    res.value = '0;
    res.err   = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (raw[4*d +: 4] > BCD_MAX) begin
        res.err = 1'b1;
      end else begin
        res.value[4*d +: 4] = raw[4*d +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first asserted request scanning
// upward from last+1, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  int best_d;
  int d;

  // Each candidate's distance after last; the nearest asserted one wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    best_d = N;
    d      = 0;
    for (int i = 0; i < N; i++) begin
      d = (i + N - 1 - int'(last)) % N;
      if (req[i] && (d < best_d)) begin
        best_d = d;
        winner = IDX_W'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Round-robin arbiter sharing one 4-digit 7-segment display between
// NUM_SRC requesters, with fixed dwell slices and BCD sanitising.
module seg7_display_arbiter
  import seg7_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = DWELL_DEFAULT,
  parameter int TMR_W        = 26
) (
  input  logic                  clk_50MHz,
  input  logic                  reset_button,
  input  logic [NUM_SRC-1:0]    req,
  input  logic [16*NUM_SRC-1:0] bcd_in,
  input  logic                  hold,
  output logic [15:0]           bcd_out,
  output logic [NUM_SRC-1:0]    grant,
  output logic                  active,
  output logic                  dwell_done,
  output logic                  bcd_err
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_SRC - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             err_q, err_d;
  logic             dwell_q, dwell_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             req_cur;
  logic [15:0]      bcd_sel;
  bcd_clean_t       clean;

  // In SHOW, last_q is the granted source, so one finder serves both
  // the initial pick and rotation/release (which must skip the current one).
  rr_pick #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .last   (last_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    grant   = '0;
    req_cur = 1'b0;
    bcd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (last_q == IDX_W'(i)) begin
        grant[i] = (state_q == ST_SHOW);
        req_cur  = req[i];
        bcd_sel  = bcd_in[16*i +: 16];
      end
    end
    clean = bcd_sanitise(bcd_sel);
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    timer_d = timer_q;
    bcd_d   = bcd_q;
    err_d   = err_q;
    dwell_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bcd_d = '0;
        err_d = 1'b0;
        if (pick_valid) begin
          state_d = ST_SHOW;
          last_d  = pick_idx;
          timer_d = '0;
        end
      end

      ST_SHOW: begin
        bcd_d = clean.value;
        err_d = clean.err;
        // Release outranks both hold and expiry; no dwell pulse on release.
        if (!req_cur) begin
          timer_d = '0;
          if (pick_valid) begin
            last_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
            bcd_d   = '0;
            err_d   = 1'b0;
          end
        end else if (timer_q == TMR_LAST) begin
          dwell_d = 1'b1;
          timer_d = '0;
          if (!hold) begin
            last_d = pick_idx;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset_button) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_RST;
      timer_q <= '0;
      bcd_q   <= '0;
      err_q   <= 1'b0;
      dwell_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
      dwell_q <= dwell_d;
    end
  end

  assign bcd_out    = bcd_q;
  assign bcd_err    = err_q;
  assign dwell_done = dwell_q;
  assign active     = (state_q == ST_SHOW);

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Self-checking bench for seg7_display_arbiter: directed plan scenarios
// followed by random traffic, all compared against a behavioural model.
module tb_seg7_display_arbiter;

  localparam int N     = 4;
  localparam int DWELL = 8;

  logic            clk_50MHz = 1'b0;
  logic            reset_button;
  logic [N-1:0]    req;
  logic [16*N-1:0] bcd_in;
  logic            hold;
  logic [15:0]     bcd_out;
  logic [N-1:0]    grant;
  logic            active;
  logic            dwell_done;
  logic            bcd_err;

  logic [15:0] src [N];

  int n_checks = 0;
  int n_errors = 0;

  // Model: which source owns the display (-1 = none), the round-robin
  // pointer, and how many cycles of the current slice have elapsed.
  int          m_owner;
  int          m_ptr;
  int          m_age;
  logic [15:0] m_bcd;
  bit          m_err;
  bit          m_dwell;

  seg7_display_arbiter #(
    .NUM_SRC      (N),
    .DWELL_CYCLES (DWELL),
    .TMR_W        (4)
  ) dut (
    .clk_50MHz    (clk_50MHz),
    .reset_button (reset_button),
    .req          (req),
    .bcd_in       (bcd_in),
    .hold         (hold),
    .bcd_out      (bcd_out),
    .grant        (grant),
    .active       (active),
    .dwell_done   (dwell_done),
    .bcd_err      (bcd_err)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  always_comb begin
    bcd_in = '0;
    for (int i = 0; i < N; i++) bcd_in[16*i +: 16] = src[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int next_requester(input logic [N-1:0] r, input int after);
    for (int k = 1; k <= N; k++) begin
      if (r[(after + k) % N]) return (after + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [16:0] clean_digits(input logic [15:0] v);
    int          digit;
    logic [15:0] res = 16'h0000;
    logic        bad = 1'b0;
    for (int p = 0; p < 4; p++) begin
      digit = (int'(v) >> (4 * p)) % 16;
      if (digit > 9) bad = 1'b1;
      else res = res + 16'(digit << (4 * p));
    end
    return {bad, res};
  endfunction

  task automatic model_step();
    logic [16:0] c;
    int          nxt;
    m_dwell = 1'b0;
    if (reset_button) begin
      m_owner = -1;
      m_ptr   = N - 1;
      m_age   = 0;
      m_bcd   = 16'h0000;
      m_err   = 1'b0;
      return;
    end
    if (m_owner < 0) begin
      m_bcd = 16'h0000;
      m_err = 1'b0;
      nxt   = next_requester(req, m_ptr);
      if (nxt >= 0) begin
        m_owner = nxt;
        m_ptr   = nxt;
        m_age   = 0;
      end
      return;
    end
    c     = clean_digits(src[m_owner]);
    m_bcd = c[15:0];
    m_err = c[16];
    if (!req[m_owner]) begin
      m_age = 0;
      nxt   = next_requester(req, m_owner);
      m_owner = nxt;
      if (nxt >= 0) m_ptr = nxt;
      else begin
        m_bcd = 16'h0000;
        m_err = 1'b0;
      end
    end else if (m_age + 1 == DWELL) begin
      m_dwell = 1'b1;
      m_age   = 0;
      if (!hold) begin
        m_owner = next_requester(req, m_owner);
        m_ptr   = m_owner;
      end
    end else begin
      m_age++;
    end
  endtask

  task automatic tick(input int n = 1);
    for (int c = 0; c < n; c++) begin
      @(posedge clk_50MHz);
      model_step();
      #1;
      chk("grant", 32'(grant), (m_owner < 0) ? 32'h0 : (32'h1 << m_owner));
      chk("active", 32'(active), 32'(m_owner >= 0));
      chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
      chk("bcd_err", 32'(bcd_err), 32'(m_err));
      chk("dwell_done", 32'(dwell_done), 32'(m_dwell));
    end
  endtask

  initial begin
    int budget;
    reset_button = 1'b1;
    req  = '0;
    hold = 1'b0;
    for (int i = 0; i < N; i++) src[i] = 16'h0000;
    m_owner = -1; m_ptr = N - 1; m_age = 0; m_bcd = '0; m_err = 0; m_dwell = 0;
    tick(2);
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_bcd", 32'(bcd_out), 32'h0);
    reset_button = 1'b0;

    // Single requester: grant after one cycle, value after two.
    src[0] = 16'h1234; src[1] = 16'h0815; src[2] = 16'h0042; src[3] = 16'h9999;
    req = 4'b0001;
    tick(1);
    chk("first_grant", 32'(grant), 32'h1);
    tick(1);
    chk("first_bcd", 32'(bcd_out), 32'h1234);
    tick(20);

    // Two requesters alternate each dwell slice.
    req = 4'b0101;
    tick(40);

    // Hold pins the grant across expiries.
    hold = 1'b1;
    tick(30);
    hold = 1'b0;
    tick(20);

    // Release mid-slice hands over without a dwell pulse.
    req = 4'b1100;
    budget = 0;
    while (!(m_owner == 2 && m_age == 3) && budget < 60) begin
      tick(1);
      budget++;
    end
    chk("wait_src2_age3", 32'(budget < 60), 32'h1);
    req = 4'b1000;
    tick(1);
    chk("release_grant", 32'(grant), 32'h8);
    chk("release_no_dwell", 32'(dwell_done), 32'h0);
    tick(10);
    req = 4'b0000;
    tick(3);
    chk("idle_grant", 32'(grant), 32'h0);
    chk("idle_bcd", 32'(bcd_out), 32'h0);

    // Sanitising of non-BCD nibbles.
    src[1] = 16'h9A3F;
    req = 4'b0010;
    tick(3);
    chk("sanitise_bcd", 32'(bcd_out), 32'h9030);
    chk("sanitise_err", 32'(bcd_err), 32'h1);
    src[1] = 16'h0815;
    tick(2);
    chk("clean_bcd", 32'(bcd_out), 32'h0815);
    chk("clean_err", 32'(bcd_err), 32'h0);

    // Reset mid-slice discards the grant; source 0 wins afterwards.
    req = 4'b0011;
    tick(12);
    reset_button = 1'b1;
    tick(1);
    chk("midreset_grant", 32'(grant), 32'h0);
    reset_button = 1'b0;
    tick(1);
    chk("postreset_grant", 32'(grant), 32'h1);
    tick(8);

    // Random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 11) == 0) req[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 29) == 0) hold = ~hold;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 2) == 0) src[$urandom_range(0, N - 1)] = 16'($urandom);
        else src[$urandom_range(0, N - 1)] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                              4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end
      reset_button = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    reset_button = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
